line_endpoint_gen: RTL and testbench

//  Inverse of the rho stage: converts one Hough peak (rho, theta as CORDIC sin/cos) back to image space.

---
 rtl/line_endpoint_gen.sv | 220 ++++++++++++++++++++++
 tb/tb_line_endpoint_gen.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/line_endpoint_gen.sv
// Converts one Hough peak (rho, CORDIC sin/cos) into a lane segment (x0,Y_TOP)-(x1,Y_BOT)
// using a single shared restoring divider, one quotient bit per cycle.
module line_endpoint_gen #(
  parameter int unsigned IMG_W   = 1280,
  parameter int unsigned Y_TOP   = 360,
  parameter int unsigned Y_BOT   = 719,
  parameter int unsigned COS_MIN = 256
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_vld,
  output logic        in_rdy,
  input  logic        interest_part,
  input  logic [27:0] rho,
  input  logic [31:0] sin,
  input  logic [31:0] cos,
  output logic        out_vld,
  output logic [11:0] x0,
  output logic [11:0] x1,
  output logic [11:0] y0,
  output logic [11:0] y1,
  output logic [1:0]  out_clip,
  output logic        out_err
);

  typedef enum logic [2:0] {StIdle, StLoad, StDiv0, StDiv1, StOut} state_e;

  state_e      state_q, state_d;
  logic        ip_q, ip_d;
  logic [27:0] rho_q, rho_d;
  logic [31:0] sin_q, sin_d, cos_q, cos_d;
  logic [31:0] den_q, den_d;
  logic [31:0] rem_q, rem_d;
  logic [43:0] num_q, num_d;
  logic [43:0] n1_q, n1_d;
  logic [43:0] q0_q, q0_d;
  logic        neg0_q, neg0_d, neg1_q, neg1_d;
  logic        err_q, err_d;
  logic [5:0]  cnt_q, cnt_d;
  logic        out_vld_q, out_vld_d;
  logic [11:0] x0_q, x0_d, x1_q, x1_d, y0_q, y0_d, y1_q, y1_d;
  logic [1:0]  clip_q, clip_d;
  logic        out_err_q, out_err_d;

  logic [31:0]        cos_abs;
  logic signed [44:0] a_s, sin_ext, y_top_s, y_bot_s, b0, b1, n0, n1;
  logic [43:0]        n0_mag, n1_mag, num_step;
  logic [32:0]        rem_sh;
  logic [31:0]        rem_nx;
  logic               ge;
  logic [12:0]        c0, c1;

  // Returns {clip, x}: negative quotients clamp to 0, large ones to IMG_W-1.
  function automatic logic [12:0] clamp_x(input logic [43:0] q, input logic neg);
    logic [12:0] r;
    if (neg && (q != 44'd0)) begin
      r = {1'b1, 12'd0};
    end else if (q > 44'(IMG_W - 1)) begin
      r = {1'b1, 12'(IMG_W - 1)};
    end else begin
      r = {1'b0, q[11:0]};
    end
    return r;
  endfunction

  always_comb begin
    cos_abs = cos_q[31] ? (~cos_q + 32'd1) : cos_q;
    a_s     = $signed({1'b0, rho_q, 16'd0});
    sin_ext = $signed({{13{sin_q[31]}}, sin_q});
    y_top_s = $signed(45'(Y_TOP));
    y_bot_s = $signed(45'(Y_BOT));
    b0      = y_top_s * sin_ext;
    b1      = y_bot_s * sin_ext;
    n0      = ip_q ? (a_s - b0) : (b0 - a_s);
    n1      = ip_q ? (a_s - b1) : (b1 - a_s);
    n0_mag  = n0[44] ? (~n0[43:0] + 44'd1) : n0[43:0];
    n1_mag  = n1[44] ? (~n1[43:0] + 44'd1) : n1[43:0];

    // Quotient bits shift into num_q from the LSB as dividend bits leave the MSB.
    rem_sh   = {rem_q, num_q[43]};
    ge       = rem_sh >= {1'b0, den_q};
    rem_nx   = ge ? 32'(rem_sh - {1'b0, den_q}) : rem_sh[31:0];
    num_step = {num_q[42:0], ge};
    c0       = clamp_x(q0_q, neg0_q);
    c1       = clamp_x(num_step, neg1_q);
  end

  always_comb begin
    state_d   = state_q;
    ip_d      = ip_q;
    rho_d     = rho_q;
    sin_d     = sin_q;
    cos_d     = cos_q;
    den_d     = den_q;
    rem_d     = rem_q;
    num_d     = num_q;
    n1_d      = n1_q;
    q0_d      = q0_q;
    neg0_d    = neg0_q;
    neg1_d    = neg1_q;
    err_d     = err_q;
    cnt_d     = cnt_q;
    out_vld_d = 1'b0;
    x0_d      = x0_q;
    x1_d      = x1_q;
    y0_d      = y0_q;
    y1_d      = y1_q;
    clip_d    = clip_q;
    out_err_d = out_err_q;
    unique case (state_q)
      StIdle: begin
        if (in_vld) begin
          ip_d    = interest_part;
          rho_d   = rho;
          sin_d   = sin;
          cos_d   = cos;
          state_d = StLoad;
        end
      end
      StLoad: begin
        den_d   = cos_abs;
        err_d   = cos_abs < COS_MIN;
        num_d   = n0_mag;
        n1_d    = n1_mag;
        neg0_d  = n0[44];
        neg1_d  = n1[44];
        rem_d   = 32'd0;
        cnt_d   = 6'd0;
        state_d = StDiv0;
      end
      StDiv0: begin
        rem_d = rem_nx;
        num_d = num_step;
        cnt_d = cnt_q + 6'd1;
        if (cnt_q == 6'd43) begin
          q0_d    = num_step;
          num_d   = n1_q;
          rem_d   = 32'd0;
          cnt_d   = 6'd0;
          state_d = StDiv1;
        end
      end
      StDiv1: begin
        rem_d = rem_nx;
        num_d = num_step;
        cnt_d = cnt_q + 6'd1;
        if (cnt_q == 6'd43) begin
          state_d   = StOut;
          out_vld_d = 1'b1;
          x0_d      = err_q ? 12'd0 : c0[11:0];
          x1_d      = err_q ? 12'd0 : c1[11:0];
          clip_d    = err_q ? 2'b00 : {c1[12], c0[12]};
          out_err_d = err_q;
          y0_d      = 12'(Y_TOP);
          y1_d      = 12'(Y_BOT);
        end
      end
      StOut:   state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      ip_q      <= 1'b0;
      rho_q     <= '0;
      sin_q     <= '0;
      cos_q     <= '0;
      den_q     <= '0;
      rem_q     <= '0;
      num_q     <= '0;
      n1_q      <= '0;
      q0_q      <= '0;
      neg0_q    <= 1'b0;
      neg1_q    <= 1'b0;
      err_q     <= 1'b0;
      cnt_q     <= '0;
      out_vld_q <= 1'b0;
      x0_q      <= '0;
      x1_q      <= '0;
      y0_q      <= '0;
      y1_q      <= '0;
      clip_q    <= '0;
      out_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      ip_q      <= ip_d;
      rho_q     <= rho_d;
      sin_q     <= sin_d;
      cos_q     <= cos_d;
      den_q     <= den_d;
      rem_q     <= rem_d;
      num_q     <= num_d;
      n1_q      <= n1_d;
      q0_q      <= q0_d;
      neg0_q    <= neg0_d;
      neg1_q    <= neg1_d;
      err_q     <= err_d;
      cnt_q     <= cnt_d;
      out_vld_q <= out_vld_d;
      x0_q      <= x0_d;
      x1_q      <= x1_d;
      y0_q      <= y0_d;
      y1_q      <= y1_d;
      clip_q    <= clip_d;
      out_err_q <= out_err_d;
    end
  end

  assign in_rdy   = (state_q == StIdle);
  assign out_vld  = out_vld_q;
  assign x0       = x0_q;
  assign x1       = x1_q;
  assign y0       = y0_q;
  assign y1       = y1_q;
  assign out_clip = clip_q;
  assign out_err  = out_err_q;

endmodule

// File: tb/tb_line_endpoint_gen.sv
// Directed bench for line_endpoint_gen: hand-computed segment endpoints, latency,
// back-to-back handshake and mid-operation reset.
module tb_line_endpoint_gen;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        in_vld = 1'b0;
  logic        in_rdy;
  logic        interest_part = 1'b0;
  logic [27:0] rho = '0;
  logic [31:0] sin_v = '0;
  logic [31:0] cos_v = '0;
  logic        out_vld;
  logic [11:0] x0, x1, y0, y1;
  logic [1:0]  out_clip;
  logic        out_err;

  int compared = 0;
  int mism = 0;

  line_endpoint_gen dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .in_vld       (in_vld),
    .in_rdy       (in_rdy),
    .interest_part(interest_part),
    .rho          (rho),
    .sin          (sin_v),
    .cos          (cos_v),
    .out_vld      (out_vld),
    .x0           (x0),
    .x1           (x1),
    .y0           (y0),
    .y1           (y1),
    .out_clip     (out_clip),
    .out_err      (out_err)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [47:0] obs, input logic [47:0] expv);
    compared++;
    assert (obs === expv) else begin
      mism++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
    end
  endtask

  // Counts edges after the accepting edge until out_vld is sampled high (200 = timeout).
  task automatic wait_out(output int n);
    n = 0;
    while (n < 200) begin
      @(posedge clk);
      n++;
      #1;
      if (out_vld) break;
    end
  endtask

  task automatic wait_rdy(input string tag);
    int k = 0;
    @(negedge clk);
    while (!in_rdy && k < 200) begin
      @(negedge clk);
      k++;
    end
    chk({tag, "_rdy"}, 48'(in_rdy), 48'd1);
  endtask

  task automatic do_peak(input string tag, input logic ip, input logic [27:0] r,
                         input logic [31:0] s, input logic [31:0] c,
                         input logic [11:0] ex0, input logic [11:0] ex1,
                         input logic [1:0] eclip, input logic eerr);
    int n;
    wait_rdy(tag);
    interest_part = ip;
    rho           = r;
    sin_v         = s;
    cos_v         = c;
    in_vld        = 1'b1;
    @(posedge clk);
    #1;
    in_vld = 1'b0;
    chk({tag, "_busy"}, 48'(in_rdy), 48'd0);
    wait_out(n);
    chk({tag, "_lat"}, 48'(n), 48'd89);
    chk({tag, "_x0"}, 48'(x0), 48'(ex0));
    chk({tag, "_x1"}, 48'(x1), 48'(ex1));
    chk({tag, "_y0"}, 48'(y0), 48'd360);
    chk({tag, "_y1"}, 48'(y1), 48'd719);
    chk({tag, "_clip"}, 48'(out_clip), 48'(eclip));
    chk({tag, "_err"}, 48'(out_err), 48'(eerr));
    @(posedge clk);
    #1;
    chk({tag, "_vld_once"}, 48'(out_vld), 48'd0);
    chk({tag, "_rdy_back"}, 48'(in_rdy), 48'd1);
  endtask

  initial begin
    int first_vld, second_vld, rdy_low, seen;
    logic [11:0] a_x0, b_x0, b_x1;
    logic [1:0]  b_clip;

    // Reset state.
    #1 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_rdy", 48'(in_rdy), 48'd1);
    chk("rst_vld", 48'(out_vld), 48'd0);
    chk("rst_x0", 48'(x0), 48'd0);
    chk("rst_y1", 48'(y1), 48'd0);
    chk("rst_clip", 48'(out_clip), 48'd0);
    chk("rst_err", 48'(out_err), 48'd0);
    @(negedge clk);
    rst_n = 1'b1;

    do_peak("t1", 1'b1, 28'd100, 32'd0, 32'd65536, 12'd100, 12'd100, 2'b00, 1'b0);
    do_peak("t2", 1'b0, 28'd71, 32'd46341, 32'(-46341), 12'd259, 12'd618, 2'b00, 1'b0);
    do_peak("t3", 1'b1, 28'd2000, 32'd0, 32'd65536, 12'd1279, 12'd1279, 2'b11, 1'b0);
    do_peak("t4", 1'b1, 28'd50, 32'd65535, 32'd100, 12'd0, 12'd0, 2'b00, 1'b1);
    do_peak("neg", 1'b1, 28'd100, 32'd65536, 32'd65536, 12'd0, 12'd0, 2'b11, 1'b0);
    do_peak("mix", 1'b1, 28'd500, 32'd65536, 32'd65536, 12'd140, 12'd0, 2'b10, 1'b0);
    do_peak("cmin", 1'b1, 28'd1, 32'd0, 32'd256, 12'd256, 12'd256, 2'b00, 1'b0);
    do_peak("cbelow", 1'b1, 28'd1, 32'd0, 32'd255, 12'd0, 12'd0, 2'b00, 1'b1);
    do_peak("cmin2", 1'b1, 28'd1, 32'd0, 32'd256, 12'd256, 12'd256, 2'b00, 1'b0);

    // T5: back-to-back with in_vld held; second peak staged right after the first accept.
    wait_rdy("t5");
    interest_part = 1'b1;
    rho           = 28'd100;
    sin_v         = 32'd0;
    cos_v         = 32'd65536;
    in_vld        = 1'b1;
    @(posedge clk);
    #1;
    rho        = 28'd2000;
    first_vld  = 0;
    second_vld = 0;
    rdy_low    = in_rdy ? 0 : 1;
    a_x0       = '0;
    b_x0       = '0;
    b_x1       = '0;
    b_clip     = '0;
    for (int n = 1; n <= 200; n++) begin
      @(posedge clk);
      #1;
      if (n == 91) in_vld = 1'b0;
      if (n <= 90 && !in_rdy) rdy_low++;
      if (out_vld && first_vld == 0) begin
        first_vld = n;
        a_x0      = x0;
      end else if (out_vld && second_vld == 0) begin
        second_vld = n;
        b_x0       = x0;
        b_x1       = x1;
        b_clip     = out_clip;
      end
    end
    chk("t5_rdy_low", 48'(rdy_low), 48'd90);
    chk("t5_first_lat", 48'(first_vld), 48'd89);
    chk("t5_gap", 48'(second_vld - first_vld), 48'd91);
    chk("t5_a_x0", 48'(a_x0), 48'd100);
    chk("t5_b_x0", 48'(b_x0), 48'd1279);
    chk("t5_b_x1", 48'(b_x1), 48'd1279);
    chk("t5_b_clip", 48'(b_clip), 48'd3);

    // T6: reset pulse during DIV1 aborts the peak.
    wait_rdy("t6");
    interest_part = 1'b0;
    rho           = 28'd71;
    sin_v         = 32'd46341;
    cos_v         = 32'(-46341);
    in_vld        = 1'b1;
    @(posedge clk);
    #1;
    in_vld = 1'b0;
    repeat (60) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("t6_x0", 48'(x0), 48'd0);
    chk("t6_x1", 48'(x1), 48'd0);
    chk("t6_y0", 48'(y0), 48'd0);
    chk("t6_clip", 48'(out_clip), 48'd0);
    chk("t6_rdy", 48'(in_rdy), 48'd1);
    @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    repeat (120) begin
      @(posedge clk);
      #1;
      if (out_vld) seen = 1;
    end
    chk("t6_no_vld", 48'(seen), 48'd0);
    do_peak("t6b", 1'b0, 28'd71, 32'd46341, 32'(-46341), 12'd259, 12'd618, 2'b00, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mism);
    $finish;
  end

endmodule
